// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants, instruction field positions and fetch state enum
package cpu_pkg;
  localparam int OPC_W = 4;
  localparam logic [OPC_W-1:0] OPC_STORE = 4'b0010;
  localparam logic [OPC_W-1:0] OPC_LOADI = 4'b1011;
  localparam logic [OPC_W-1:0] OPC_HALT  = 4'b1111;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int REG_MSB = 11;
  localparam int REG_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  typedef enum logic [1:0] {FETCH, WAIT, ISSUE, HALT} fetch_state_e;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: W-bit address register with load/increment(modulo 2^W)/hold; ports clk rst ld inc d q
module pc_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d, q_q;
  always_comb q_d = ld ? d : inc ? q_q + W'(1) : q_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC + sync imem read + IR with valid/stall handshake and branch redirect; ports clk rst imem_rd_en imem_addr imem_data stall branch_en branch_target instr_valid opcode reg_field imm pc halted; FETCH_HALT_EN makes opcode 4'hF halt fetch
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_rd_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               branch_en,
  input  logic [PC_W-1:0]    branch_target,
  output logic               instr_valid,
  output logic [OPC_W-1:0]   opcode,
  output logic [3:0]         reg_field,
  output logic [7:0]         imm,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);
  fetch_state_e state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_next;
  logic hs, halt_op;
`ifdef FETCH_HALT_EN
  assign halt_op = ir_q[OPC_MSB:OPC_LSB] == OPC_HALT;
  assign halted  = state_q == HALT;
`else
  assign halt_op = 1'b0;
  assign halted  = 1'b0;
`endif
  always_comb begin
    hs = state_q == ISSUE && !stall;
    state_d = state_q == FETCH ? WAIT :
              state_q == WAIT  ? ISSUE :
              state_q == ISSUE ? (stall ? ISSUE : halt_op ? HALT : FETCH) : HALT;
    ir_d = state_q == WAIT ? imem_data : ir_q;
    pc_d = state_q == WAIT ? pc_next : pc_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
    end
  pc_reg #(.W(PC_W)) u_pc (
    .clk (clk),
    .rst (rst),
    .ld  (hs && branch_en && !halt_op),
    .inc (hs && !branch_en && !halt_op),
    .d   (branch_target),
    .q   (pc_next)
  );
  assign imem_rd_en  = state_q == FETCH && !rst;
  assign imem_addr   = pc_next;
  assign instr_valid = state_q == ISSUE;
  assign opcode      = ir_q[OPC_MSB:OPC_LSB];
  assign reg_field   = ir_q[REG_MSB:REG_LSB];
  assign imm         = ir_q[IMM_MSB:IMM_LSB];
  assign pc          = pc_q;
endmodule
